// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline encodings for the hazard controller
package pipe_hazard_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;
  localparam int REG_AW = 5;
  localparam logic [1:0] NOP_ALU_OP = 2'b00;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID source operand that depends on the load currently in EX
// ports: rs_addr/rt_addr/rs_use/rt_use from ID, rd_addr/mem_read from EX, hazard out
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              rs_use,
  input  logic              rt_use,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              mem_read,
  output logic              hazard
);
  assign hazard = mem_read && rd_addr != '0 &&
                  ((rs_use && rs_addr == rd_addr) || (rt_use && rt_addr == rd_addr));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and MULT/DIV hold sequencing for the 5-stage pipe
// ports: clk, rst_n (sync, active-low); ID operand info and EX load/branch status in;
// pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, md_start, md_busy out.
// HAZ_STAT_EN adds saturating stall_cnt and flush_cnt outputs. State updates on negedge clk.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_use,
  input  logic              id_rt_use,
  input  logic              id_md_op,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              md_start,
  output logic              md_busy
`ifdef HAZ_STAT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic lu, run, flush, stall, issue;
  load_use_detect u_lud (
    .rs_addr(id_rs_addr), .rt_addr(id_rt_addr), .rs_use(id_rs_use), .rt_use(id_rt_use),
    .rd_addr(ex_rd_addr), .mem_read(ex_mem_read), .hazard(lu)
  );
  // flush outranks load-use, and a flushed MULT/DIV never issues
  assign run   = state == RUN;
  assign flush = run && ex_branch_taken;
  assign stall = run && !ex_branch_taken && lu;
  assign issue = run && !ex_branch_taken && !lu && id_md_op;
  assign pc_en         = run && !stall;
  assign if_id_en      = run && !stall;
  assign if_id_flush   = flush;
  assign id_ex_en      = run;
  assign id_ex_bubble  = flush || stall;
  assign ex_mem_bubble = !run;
  assign md_busy       = !run;
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      cnt      <= '0;
      md_start <= 1'b0;
    end else begin
      md_start <= issue;
      state    <= issue ? MD_WAIT : (!run && cnt == CNT_W'(1)) ? RUN : state;
      cnt      <= issue ? CNT_W'(MD_LAT - 1) : !run ? cnt - CNT_W'(1) : cnt;
    end
  end
`ifdef HAZ_STAT_EN
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {15'd0, (stall || !run) && !(&stall_cnt)};
      flush_cnt <= flush_cnt + {15'd0, flush && !(&flush_cnt)};
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int MD_LAT = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs_addr = '0, id_rt_addr = '0, ex_rd_addr = '0;
  logic id_rs_use = 0, id_rt_use = 0, id_md_op = 0, ex_mem_read = 0, ex_branch_taken = 0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, md_start, md_busy;
`ifdef HAZ_STAT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  int tests = 0, fails = 0, starts = 0;
  int md_left = 0;
  bit md_first = 0;
  int m_stall = 0, m_flush = 0;
  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
    .id_md_op(id_md_op), .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble), .md_start(md_start), .md_busy(md_busy)
`ifdef HAZ_STAT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, o, e, $time);
    end
  endtask
  // one pipeline cycle: drive after posedge, check before the committing negedge, advance model
  task automatic step(input bit r, input logic [4:0] rs, rt, rd, input bit rsu, rtu, md, mr, br);
    bit lu, issue, stalled, flushed;
    @(posedge clk);
    rst_n = r; id_rs_addr = rs; id_rt_addr = rt; ex_rd_addr = rd;
    id_rs_use = rsu; id_rt_use = rtu; id_md_op = md; ex_mem_read = mr; ex_branch_taken = br;
    #1;
    lu = mr && rd != 0 && ((rsu && rs == rd) || (rtu && rt == rd));
    if (md_left > 0) begin
      chk("pc_en", pc_en, 0); chk("if_id_en", if_id_en, 0); chk("id_ex_en", id_ex_en, 0);
      chk("if_id_flush", if_id_flush, 0); chk("id_ex_bubble", id_ex_bubble, 0);
      chk("ex_mem_bubble", ex_mem_bubble, 1); chk("md_busy", md_busy, 1);
      chk("md_start", md_start, 16'(md_first));
      issue = 0; stalled = 1; flushed = 0;
    end else begin
      flushed = br; stalled = !br && lu; issue = !br && !lu && md;
      chk("pc_en", pc_en, 16'(!stalled)); chk("if_id_en", if_id_en, 16'(!stalled));
      chk("id_ex_en", id_ex_en, 1); chk("if_id_flush", if_id_flush, 16'(flushed));
      chk("id_ex_bubble", id_ex_bubble, 16'(flushed || stalled));
      chk("ex_mem_bubble", ex_mem_bubble, 0); chk("md_busy", md_busy, 0); chk("md_start", md_start, 0);
    end
`ifdef HAZ_STAT_EN
    chk("stall_cnt", stall_cnt, 16'(m_stall)); chk("flush_cnt", flush_cnt, 16'(m_flush));
`endif
    if (md_start === 1'b1) starts++;
    if (!r) begin
      md_left = 0; md_first = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_stall += int'(stalled); m_flush += int'(flushed);
      if (md_left > 0) begin md_left--; md_first = 0; end
      else if (issue) begin md_left = MD_LAT - 1; md_first = 1; end
    end
  endtask
  task automatic idle(input bit md);
    step(1, 0, 0, 0, 0, 0, md, 0, 0);
  endtask
  initial begin
    rst_n = 0;
    repeat (2) @(negedge clk);
    idle(0);
    step(1, 5, 0, 5, 1, 0, 0, 1, 0);
    idle(0);
    step(1, 0, 0, 0, 1, 1, 0, 1, 0);
    step(1, 3, 7, 7, 0, 1, 0, 1, 0);
    step(1, 4, 0, 4, 1, 0, 0, 1, 1);
    step(1, 6, 0, 6, 1, 0, 1, 1, 0);
    step(1, 6, 0, 0, 1, 0, 1, 0, 0);
    repeat (3) idle(0);
    starts = 0;
    idle(1); repeat (3) idle(1); idle(1); repeat (3) idle(0);
    chk("md_start_pulses", 16'(starts), 2);
    step(1, 2, 0, 2, 1, 0, 1, 1, 1);
    idle(1); idle(0); step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0); idle(0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
           1'($urandom), $urandom_range(0, 5) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
